scancode_decoder: RTL and testbench
===================================

SCANCODE_DECODER -- requirements
Module: scancode_decoder

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, number of buffered key events; power of two, 2..64.
REQ-002 Parameter: EMIT_RELEASE, 0, 1 = key-up events are also queued; 0 = key-up events update state only.
REQ-003 Parameter: AUTOREPEAT, 1, 1 = repeated make of a held key is queued; 0 = suppressed.
REQ-004 Parameter: EMIT_MODS, 0, 1 = modifier make/break also queued as events; 0 = modifiers update state only.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-006 Port: clk  in  1  rising-edge clock.
REQ-007 Port: reset  in  1  asynchronous active-high reset.
REQ-008 Port: strobe_in  in  1  one-cycle qualifier for code_in; one PS/2 set-2 byte per strobe.
REQ-009 Port: code_in  in  8  received scancode byte.
REQ-010 Port: keycode  out  12  head-of-FIFO event: [6:0] scancode, [7] extended (E0), [8] shift, [9] ctrl, [10] meta, [11] release.
REQ-011 Port: strobe_out  out  1  keycode valid (FIFO not empty).
REQ-012 Port: ack  in  1  consumer pop; effective only when strobe_out=1.
REQ-013 Port: overflow  out  1  sticky: an event was dropped because the FIFO was full.
REQ-014 Port: clear_overflow  in  1  synchronous clear of overflow.

Function
REQ-015 The parser SHALL have states IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0) and SKIP (E1 sequence). It SHALL advance only on cycles with strobe_in=1.
REQ-016 IDLE transitions: E0->EXT; F0->BRK; E1->SKIP with skip counter=7; bytes 00, AA, EE, FA, FC, FD, FE, FF are ignored and stay in IDLE. Any other byte with bit7=0 is a make event with ext=0 and stays in IDLE. Any other byte with bit7=1 is dropped.
REQ-017 EXT transitions: F0->EXT_BRK; E0 stays in EXT; E0 12 and E0 59 (fake shifts) are dropped and return to IDLE; otherwise a make with ext=1, then IDLE.
REQ-018 BRK/EXT_BRK SHALL produce a break event with ext=0/1 respectively and then go to IDLE.
REQ-019 SKIP SHALL decrement the counter per strobe; on the 7th byte it goes to IDLE; no events are produced.
REQ-020 Modifier keys: 12/59 shift (left/right tracked separately), 14 ctrl, E0 14 ctrl, 11 meta, E0 11 meta (left/right tracked separately). Output modifier bit = OR of left and right.
REQ-021 Modifier make/break SHALL update modifier state at the same edge the byte is sampled.
REQ-022 A queued event SHALL carry the modifier bits as they were before that edge.
REQ-023 A pressed-key bitmap of 256 entries ({ext, code[6:0]}) SHALL be set on make and cleared on break.
REQ-024 With AUTOREPEAT=0, a make whose bit is already set SHALL NOT be queued.
REQ-025 Queueing: a non-modifier make is always queued (subject to REQ-024). A break is queued only if EMIT_RELEASE=1. A modifier event is queued only if EMIT_MODS=1.
REQ-026 Latency: an event whose final byte is sampled at edge N SHALL be written at edge N. strobe_out=1 and keycode are valid from edge N when the FIFO was empty.
REQ-027 FIFO: pop at each edge with ack=1 and strobe_out=1. Order is strict FIFO.
REQ-028 Simultaneous push and pop when full: both succeed and the count is unchanged.
REQ-029 Push when full without pop: the event is dropped, overflow is set, and FIFO contents are unchanged.
REQ-030 Pop when empty is ignored.
REQ-031 Simultaneous push and pop when empty: count becomes 1 and the new event is presented.
REQ-032 Pointers SHALL wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.
REQ-033 If clear_overflow and a new overflow occur in the same cycle, overflow SHALL remain 1.

Reset
REQ-034 Asynchronous reset SHALL force: state=IDLE, skip counter=0, modifiers=0, bitmap=0, FIFO empty, strobe_out=0, keycode=0, overflow=0.
REQ-035 Reset mid-sequence (e.g. after E0) SHALL discard the partial sequence; the first byte after reset is parsed from IDLE.

Verification
REQ-036 Press a: 1C, F0, 1C with defaults -> exactly one event keycode=0x01C; no release event.
REQ-037 Shift+a with EMIT_RELEASE=1: 12, 1C, F0 1C, F0 12 -> events 0x11C then 0x91C; no shift events; shift=0 afterwards.
REQ-038 Extended ctrl+up arrow: E0 14, E0 75, E0 F0 75, E0 F0 14 -> one event 0x2F5; right-ctrl state cleared at end.
REQ-039 Pause key: E1 14 77 E1 F0 14 F0 77 followed by 1C -> only event 0x01C; AUTOREPEAT=0 with 1C 1C 1C -> single 0x01C.
REQ-040 Overflow: FIFO_DEPTH=4, ack=0, six make codes -> first four retained in order, overflow=1. Then ack on the same edge as a new make -> count stays 4. clear_overflow -> 0.
REQ-041 Reset asserted between E0 and 75 -> all outputs 0. Subsequent 75 -> event 0x075 (ext=0).

Source files
------------

// File: rtl/scancode_decoder_if.sv
// Byte-in / key-event-out bus of the PS/2 set-2 scancode decoder.
interface scancode_decoder_if;
  logic        strobe_in;
  logic [7:0]  code_in;
  logic [11:0] keycode;
  logic        strobe_out;
  logic        ack;
  logic        overflow;
  logic        clear_overflow;

  // Byte source and event consumer
  modport master (
    output strobe_in, code_in, ack, clear_overflow,
    input  keycode, strobe_out, overflow
  );

  // Decoder side
  modport slave (
    input  strobe_in, code_in, ack, clear_overflow,
    output keycode, strobe_out, overflow
  );
endinterface

// File: rtl/scancode_decoder.sv
// PS/2 set-2 scancode decoder: parses make/break/extended sequences, tracks
// modifiers and a pressed-key bitmap, and queues key events in a small FIFO.
module scancode_decoder #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter bit          EMIT_RELEASE = 1'b0,
  parameter bit          AUTOREPEAT   = 1'b1,
  parameter bit          EMIT_MODS    = 1'b0
) (
  input logic               clk,
  input logic               reset,
  scancode_decoder_if.slave bus
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {StIdle, StExt, StBrk, StExtBrk, StSkip} state_e;

  state_e       state_q, state_d;
  logic [2:0]   skip_q, skip_d;
  // {meta_r, meta_l, ctrl_r, ctrl_l, shift_r, shift_l}
  logic [5:0]   mods_q, mods_d;
  logic [255:0] pressed_q;

  logic         ev_valid, ev_ext, ev_rel;
  logic [6:0]   ev_code;
  logic [7:0]   key;
  logic [5:0]   mod_sel;
  logic         is_mod, push;
  logic [11:0]  ev_word;

  logic [11:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          full, empty, pop, wr_en, ovf_set;
  logic          overflow_q;

  // Parser next state and the event produced by the byte sampled this cycle
  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    ev_valid = 1'b0;
    ev_ext   = 1'b0;
    ev_rel   = 1'b0;
    ev_code  = bus.code_in[6:0];
    if (bus.strobe_in) begin
      case (state_q)
        StIdle: begin
          case (bus.code_in)
            8'hE0: state_d = StExt;
            8'hF0: state_d = StBrk;
            8'hE1: begin
              state_d = StSkip;
              skip_d  = 3'd7;
            end
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: ;
            default: ev_valid = ~bus.code_in[7];
          endcase
        end
        StExt: begin
          if (bus.code_in == 8'hF0) begin
            state_d = StExtBrk;
          end else if (bus.code_in != 8'hE0) begin
            state_d = StIdle;
            // E0 12 / E0 59 are fake shifts emitted around some extended keys
            if (bus.code_in != 8'h12 && bus.code_in != 8'h59) begin
              ev_valid = 1'b1;
              ev_ext   = 1'b1;
            end
          end
        end
        StBrk: begin
          ev_valid = 1'b1;
          ev_rel   = 1'b1;
          state_d  = StIdle;
        end
        StExtBrk: begin
          ev_valid = 1'b1;
          ev_rel   = 1'b1;
          ev_ext   = 1'b1;
          state_d  = StIdle;
        end
        StSkip: begin
          if (skip_q <= 3'd1) begin
            skip_d  = 3'd0;
            state_d = StIdle;
          end else begin
            skip_d = skip_q - 3'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Modifier decode, queue decision and event word (pre-edge modifiers)
  always_comb begin
    key     = {ev_ext, ev_code};
    mod_sel = '0;
    case (key)
      8'h12:   mod_sel = 6'b000001;
      8'h59:   mod_sel = 6'b000010;
      8'h14:   mod_sel = 6'b000100;
      8'h94:   mod_sel = 6'b001000;
      8'h11:   mod_sel = 6'b010000;
      8'h91:   mod_sel = 6'b100000;
      default: mod_sel = '0;
    endcase
    is_mod  = |mod_sel;
    mods_d  = ev_rel ? (mods_q & ~mod_sel) : (mods_q | mod_sel);
    push    = ev_valid && (!is_mod || EMIT_MODS) &&
              (ev_rel ? EMIT_RELEASE : (AUTOREPEAT || !pressed_q[key]));
    ev_word = {ev_rel, mods_q[5] | mods_q[4], mods_q[3] | mods_q[2],
               mods_q[1] | mods_q[0], ev_ext, ev_code};
  end

  // Parser state, modifier state and pressed-key bitmap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      skip_q    <= '0;
      mods_q    <= '0;
      pressed_q <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      if (ev_valid) begin
        mods_q         <= mods_d;
        pressed_q[key] <= ~ev_rel;
      end
    end
  end

  // FIFO control: a pop frees the slot so a push into a full FIFO still lands
  always_comb begin
    full    = (count_q == CW'(FIFO_DEPTH));
    empty   = (count_q == '0);
    pop     = bus.ack && !empty;
    wr_en   = push && (!full || pop);
    ovf_set = push && full && !pop;
  end

  // FIFO storage; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= ev_word;
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(wr_en) - CW'(pop);
      // A new drop wins over a simultaneous clear
      if (ovf_set)                 overflow_q <= 1'b1;
      else if (bus.clear_overflow) overflow_q <= 1'b0;
    end
  end

  // Head-of-FIFO presentation
  always_comb begin
    bus.strobe_out = !empty;
    bus.keycode    = empty ? 12'h000 : mem_q[rd_ptr_q];
    bus.overflow   = overflow_q;
  end

endmodule

// File: tb/tb_scancode_decoder.sv
// Directed bench for scancode_decoder: table of byte sequences with expected
// event lists, plus hand-written FIFO, overflow and reset sequences.
module tb_scancode_decoder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  scancode_decoder_if ifa ();
  scancode_decoder_if ifb ();
  scancode_decoder_if ifc ();

  // a: defaults; b: releases queued, no autorepeat; c: releases and modifiers queued
  scancode_decoder #(.FIFO_DEPTH(4)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  scancode_decoder #(.FIFO_DEPTH(4), .EMIT_RELEASE(1'b1), .AUTOREPEAT(1'b0))
    dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));
  scancode_decoder #(.FIFO_DEPTH(8), .EMIT_RELEASE(1'b1), .EMIT_MODS(1'b1))
    dut_c (.clk(clk), .reset(reset), .bus(ifc.slave));

  typedef struct {
    string       name;
    int          dut;
    int          len;
    logic [95:0] bytes;  // first byte in the most significant used position
    int          n;
    logic [47:0] exp;    // first event in the most significant used position
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // {overflow, strobe_out, keycode} of the selected instance
  function automatic logic [13:0] peek(input int d);
    case (d)
      0:       return {ifa.overflow, ifa.strobe_out, ifa.keycode};
      1:       return {ifb.overflow, ifb.strobe_out, ifb.keycode};
      default: return {ifc.overflow, ifc.strobe_out, ifc.keycode};
    endcase
  endfunction

  task automatic drive(input logic s, input logic [7:0] b, input int d, input logic a,
                       input logic c);
    ifa.strobe_in = s; ifa.code_in = b;
    ifb.strobe_in = s; ifb.code_in = b;
    ifc.strobe_in = s; ifc.code_in = b;
    ifa.ack = a && d == 0; ifa.clear_overflow = c && d == 0;
    ifb.ack = a && d == 1; ifb.clear_overflow = c && d == 1;
    ifc.ack = a && d == 2; ifc.clear_overflow = c && d == 2;
  endtask

  // One clock with the given inputs, returning #1 after the edge
  task automatic step(input logic s, input logic [7:0] b, input int d, input logic a,
                      input logic c);
    @(negedge clk);
    drive(s, b, d, a, c);
    @(posedge clk);
    #1;
    drive(1'b0, 8'h00, d, 1'b0, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    step(1'b1, b, 0, 1'b0, 1'b0);
  endtask

  task automatic pop(input int d);
    step(1'b0, 8'h00, d, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 8'h00, 0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic expect_event(input string name, input int d, input logic [11:0] exp);
    logic [13:0] pk;
    pk = peek(d);
    check($sformatf("%s valid", name), 32'(pk[12]), 32'd1);
    check($sformatf("%s code", name), 32'(pk[11:0]), 32'(exp));
    pop(d);
  endtask

  task automatic expect_empty(input string name, input int d);
    logic [13:0] pk;
    pk = peek(d);
    check($sformatf("%s empty", name), 32'(pk[12]), 32'd0);
  endtask

  task automatic add(input string nm, input int d, input int len, input logic [95:0] b,
                     input int n, input logic [47:0] e);
    vec_t v;
    v.name = nm; v.dut = d; v.len = len; v.bytes = b; v.n = n; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    vec_t        v;
    logic [13:0] pk;
    logic [7:0]  mk [6];

    add("press_a", 0, 3, 96'({8'h1C, 8'hF0, 8'h1C}), 1, 48'(12'h01C));
    add("shift_a", 1, 7, 96'({8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h1C}),
        3, 48'({12'h11C, 12'h91C, 12'h01C}));
    add("ctrl_up", 0, 11, 96'({8'hE0, 8'h14, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75,
                               8'hE0, 8'hF0, 8'h14, 8'h1C}), 2, 48'({12'h2F5, 12'h01C}));
    add("pause", 0, 9, 96'({8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C}),
        1, 48'(12'h01C));
    add("norepeat", 1, 3, 96'({8'h1C, 8'h1C, 8'h1C}), 1, 48'(12'h01C));
    add("repeat", 0, 2, 96'({8'h1C, 8'h1C}), 2, 48'({12'h01C, 12'h01C}));
    add("ignored", 0, 6, 96'({8'hAA, 8'hFA, 8'h00, 8'hFF, 8'h83, 8'h1C}), 1, 48'(12'h01C));
    add("fake_shift", 0, 4, 96'({8'hE0, 8'h12, 8'hE0, 8'h75}), 1, 48'(12'h0F5));
    add("e0_e0", 0, 3, 96'({8'hE0, 8'hE0, 8'h71}), 1, 48'(12'h0F1));
    add("mods_emit", 2, 6, 96'({8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12}),
        4, 48'({12'h012, 12'h11C, 12'h91C, 12'h912}));
    add("meta_lr", 0, 7, 96'({8'hE0, 8'h11, 8'h11, 8'hE0, 8'hF0, 8'h11, 8'h2A}),
        1, 48'(12'h42A));
    add("ctrl_l", 0, 5, 96'({8'h14, 8'h2A, 8'hF0, 8'h14, 8'h2A}),
        2, 48'({12'h22A, 12'h02A}));
    add("ext_release", 1, 5, 96'({8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75}),
        2, 48'({12'h0F5, 12'h8F5}));

    // Reset state
    reset = 1'b1;
    drive(1'b0, 8'h00, 0, 1'b0, 1'b0);
    #1;
    pk = peek(0);
    check("reset strobe_out", 32'(pk[12]), 32'd0);
    check("reset keycode", 32'(pk[11:0]), 32'd0);
    check("reset overflow", 32'(pk[13]), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Table-driven sequences
    foreach (vecs[i]) begin
      v = vecs[i];
      do_reset();
      for (int k = 0; k < v.len; k++) send_byte(v.bytes[8*(v.len-1-k) +: 8]);
      for (int k = 0; k < v.n; k++)
        expect_event($sformatf("%s ev%0d", v.name, k), v.dut, v.exp[12*(v.n-1-k) +: 12]);
      expect_empty(v.name, v.dut);
    end

    // Overflow: six makes into a depth-4 FIFO, no ack
    do_reset();
    mk = '{8'h15, 8'h1D, 8'h1E, 8'h1F, 8'h21, 8'h22};
    for (int k = 0; k < 6; k++) send_byte(mk[k]);
    pk = peek(0);
    check("ovf set", 32'(pk[13]), 32'd1);
    check("ovf head", 32'(pk[11:0]), 32'h015);
    // Pop and push on the same edge while full
    step(1'b1, 8'h23, 0, 1'b1, 1'b0);
    pk = peek(0);
    check("ovf sticky", 32'(pk[13]), 32'd1);
    check("full pop+push head", 32'(pk[11:0]), 32'h01D);
    step(1'b0, 8'h00, 0, 1'b0, 1'b1);
    check("ovf cleared", 32'(peek(0) >> 13), 32'd0);
    // Clear coinciding with a new drop keeps the flag
    step(1'b1, 8'h24, 0, 1'b0, 1'b1);
    check("ovf clear vs set", 32'(peek(0) >> 13), 32'd1);
    step(1'b0, 8'h00, 0, 1'b0, 1'b1);
    check("ovf cleared again", 32'(peek(0) >> 13), 32'd0);
    expect_event("drain0", 0, 12'h01D);
    expect_event("drain1", 0, 12'h01E);
    expect_event("drain2", 0, 12'h01F);
    expect_event("drain3", 0, 12'h023);
    expect_empty("drain", 0);

    // Push and pop on the same edge while empty; pop on empty ignored
    do_reset();
    pop(0);
    step(1'b1, 8'h1C, 0, 1'b1, 1'b0);
    expect_event("empty pop+push", 0, 12'h01C);
    expect_empty("empty pop+push", 0);

    // Reset between E0 and 75 discards the partial sequence and queued events
    do_reset();
    send_byte(8'h1C);
    send_byte(8'hE0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    pk = peek(0);
    check("midreset strobe_out", 32'(pk[12]), 32'd0);
    check("midreset keycode", 32'(pk[11:0]), 32'd0);
    check("midreset overflow", 32'(pk[13]), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    send_byte(8'h75);
    expect_event("after reset", 0, 12'h075);
    expect_empty("after reset", 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
